pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Fetch-side consumer of the jump/branch redirect (PcSel/BrPC) from EX. Owns the PC register,
//  drives the instruction-memory address and the IF/ID pipeline register, and kills wrong-path
//  instructions on redirect. Halts the fetch on an illegal redirect target. Keeps perf counters.
// PARAMETERS
//  PC_W      9        PC width in bits; instruction-memory byte-address space is 2**PC_W
//  RESET_PC  0        PC value loaded on reset (PC_W bits, word aligned)
//  CNT_W     16       width of the saturating perf counters
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  reset          in   1      synchronous, active-high reset
//  Stall          in   1      hazard-unit stall: hold PC and IF/ID
//  PcSel          in   1      redirect taken (branch/jump resolved in EX)
//  BrPC           in   32     redirect target, valid when PcSel=1
//  Instr_In       in   32     instruction word; combinational read of Cur_PC
//  Cur_PC         out  PC_W   current fetch address to instruction memory
//  IfId_PC        out  PC_W   PC of the instruction held in IF/ID
//  IfId_Instr     out  32     instruction held in IF/ID
//  IfId_Valid     out  1      IF/ID holds a real, right-path instruction
//  Flush_IdEx     out  1      clear ID/EX on this edge (combinational)
//  Halted         out  1      fetch stopped after an illegal redirect (sticky)
//  Redirect_Cnt   out  CNT_W  number of accepted redirects (saturating)
//  Fetch_Cnt      out  CNT_W  number of instructions loaded into IF/ID as valid (saturating)
// BEHAVIOUR
//  Reset values: Cur_PC=RESET_PC, IfId_PC=0, IfId_Instr=32'h0000_0013 (NOP), IfId_Valid=0,
//   Halted=0, counters=0, state=RUN. Reset overrides every other input in the same cycle.
//  States: RUN, HALT. RUN->HALT when PcSel=1 and target illegal; HALT exits only by reset.
//  Illegal target: BrPC[1:0]!=0 or BrPC[31:PC_W]!=0. Cur_PC unchanged, IfId_Valid<=0,
//   Halted<=1, Redirect_Cnt not incremented.
//  RUN, priority per edge (highest first):
//   1) PcSel=1, legal target: Cur_PC<=BrPC[PC_W-1:0]; IfId_Valid<=0; IfId_Instr<=NOP;
//      Redirect_Cnt++. Redirect wins over Stall (PcSel=Stall=1 -> redirect, no hold).
//   2) Stall=1: Cur_PC, IfId_* and counters hold.
//   3) else: Cur_PC<=Cur_PC+4 modulo 2**PC_W (2**PC_W-4 wraps to 0); IfId_PC<=Cur_PC;
//      IfId_Instr<=Instr_In; IfId_Valid<=1; Fetch_Cnt++.
//  Flush_IdEx = PcSel & (state==RUN) & ~reset, combinational, also for an illegal target.
//   Kills the ID-stage instruction. The IF-stage instruction is killed through IfId_Valid.
//   Redirect penalty is 2 bubbles.
//  HALT: Cur_PC holds, IfId_Valid=0, Flush_IdEx=0, PcSel and Stall ignored, counters hold.
//  Counters saturate at 2**CNT_W-1; they never wrap.
//  Latency: redirect at edge N -> Cur_PC=BrPC after N; target instruction valid in IF/ID after N+1.
//  Back-to-back PcSel on consecutive cycles: each redirect is applied; the last one wins.
// STRUCTURE
//  Shared package (core pkg): fetch_state_t enum {RUN, HALT}; NOP_INSTR = 32'h0000_0013.
//  One sub-module: sat_counter #(W) (clk, reset, inc, count). Instantiated twice for the perf
//   counters. The next-PC mux, IF/ID register and FSM stay inline.
// TESTING
//  T1 reset release, Stall=0, PcSel=0: Cur_PC goes 0,4,8,12. IfId_Valid=1 from the 2nd edge.
//     IfId_PC trails Cur_PC by 4.
//  T2 PcSel=1, BrPC=0x40 at PC=0x10: Flush_IdEx=1 that cycle; next Cur_PC=0x40, IfId_Valid=0.
//     Edge after: IfId_PC=0x40, Valid=1. Redirect_Cnt=1.
//  T3 PcSel=1 and Stall=1 together, BrPC=0x80: redirect is applied (Cur_PC=0x80).
//     Stall=1 alone for 3 cycles: Cur_PC, IfId_* and Fetch_Cnt frozen.
//  T4 run from PC=0x1F8 with PC_W=9: Cur_PC goes 0x1FC then 0x000 (wrap).
//  T5 PcSel=1, BrPC=0x42 (misaligned), then separately BrPC=0x200 (out of range, after reset):
//     Halted=1, Cur_PC unchanged, IfId_Valid=0, Redirect_Cnt unchanged. Later PcSel is ignored.
//     reset -> RUN, PC=RESET_PC.
//  T6 reset asserted mid-redirect (PcSel=1, reset=1): all outputs at reset values, Flush_IdEx=0.
//     Force counter to 0xFFFF and fetch: it stays at 0xFFFF.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: fetch-stage state type and the NOP instruction word
package pc_fetch_unit_pkg;
  typedef enum logic {RUN, HALT} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/pc_fetch_unit_sat_counter.sv
// sat_counter: W-bit counter (clk, reset, inc -> count) that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, IF/ID register and redirect handling (Stall/PcSel/BrPC/Instr_In in; Cur_PC, IfId_*, Flush_IdEx, Halted, perf counters out)
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  input  logic [31:0]      Instr_In,
  output logic [PC_W-1:0]  Cur_PC,
  output logic [PC_W-1:0]  IfId_PC,
  output logic [31:0]      IfId_Instr,
  output logic             IfId_Valid,
  output logic             Flush_IdEx,
  output logic             Halted,
  output logic [CNT_W-1:0] Redirect_Cnt,
  output logic [CNT_W-1:0] Fetch_Cnt
);
  fetch_state_t state;
  logic run, legal, redirect, fetch;
  assign run        = state == RUN;
  assign legal      = BrPC[1:0] == 2'b00 && BrPC[31:PC_W] == '0;
  assign redirect   = run & PcSel & legal;
  assign fetch      = run & ~PcSel & ~Stall;
  assign Flush_IdEx = PcSel & run & ~reset;
  always_ff @(posedge clk)
    if (reset) begin
      state      <= RUN;
      Cur_PC     <= RESET_PC;
      IfId_PC    <= '0;
      IfId_Instr <= NOP_INSTR;
      IfId_Valid <= 1'b0;
      Halted     <= 1'b0;
    end else if (run) begin
      if (PcSel) begin
        IfId_Valid <= 1'b0;
        if (legal) begin
          Cur_PC     <= BrPC[PC_W-1:0];
          IfId_Instr <= NOP_INSTR;
        end else begin
          state  <= HALT;
          Halted <= 1'b1;
        end
      end else if (!Stall) begin
        Cur_PC     <= Cur_PC + PC_W'(4);
        IfId_PC    <= Cur_PC;
        IfId_Instr <= Instr_In;
        IfId_Valid <= 1'b1;
      end
    end
  sat_counter #(.W(CNT_W)) u_redirect_cnt (.clk(clk), .reset(reset), .inc(redirect), .count(Redirect_Cnt));
  sat_counter #(.W(CNT_W)) u_fetch_cnt (.clk(clk), .reset(reset), .inc(fetch), .count(Fetch_Cnt));
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scoreboard bench for pc_fetch_unit, plus a narrow-counter copy for saturation
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Stall = 1'b0;
  logic        PcSel = 1'b0;
  logic [31:0] BrPC = '0;
  logic [31:0] Instr_In;
  logic [8:0]  Cur_PC, IfId_PC, s_cur_pc, s_ifid_pc;
  logic [31:0] IfId_Instr, s_ifid_instr;
  logic        IfId_Valid, Flush_IdEx, Halted, s_valid, s_flush, s_halted;
  logic [15:0] Redirect_Cnt, Fetch_Cnt;
  logic [1:0]  s_redirect_cnt, s_fetch_cnt;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [8:0] pc; logic [8:0] ifpc; logic v; logic h;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  assign Instr_In = 32'hA500_0000 | {23'b0, Cur_PC};
  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .Stall(Stall), .PcSel(PcSel), .BrPC(BrPC), .Instr_In(Instr_In),
    .Cur_PC(Cur_PC), .IfId_PC(IfId_PC), .IfId_Instr(IfId_Instr), .IfId_Valid(IfId_Valid),
    .Flush_IdEx(Flush_IdEx), .Halted(Halted), .Redirect_Cnt(Redirect_Cnt), .Fetch_Cnt(Fetch_Cnt)
  );
  pc_fetch_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .Stall(Stall), .PcSel(PcSel), .BrPC(BrPC), .Instr_In(Instr_In),
    .Cur_PC(s_cur_pc), .IfId_PC(s_ifid_pc), .IfId_Instr(s_ifid_instr), .IfId_Valid(s_valid),
    .Flush_IdEx(s_flush), .Halted(s_halted), .Redirect_Cnt(s_redirect_cnt), .Fetch_Cnt(s_fetch_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic st, input logic ps, input logic [31:0] br,
                      input logic [8:0] epc, input logic [8:0] eif, input logic ev, input logic eh);
    exp_t e;
    Stall = st;
    PcSel = ps;
    BrPC  = br;
    sb.push_back('{epc, eif, ev, eh});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("cur_pc", 32'(Cur_PC), 32'(e.pc));
    chk("ifid_pc", 32'(IfId_PC), 32'(e.ifpc));
    chk("ifid_valid", 32'(IfId_Valid), 32'(e.v));
    chk("halted", 32'(Halted), 32'(e.h));
    if (e.v) chk("ifid_instr", IfId_Instr, 32'hA500_0000 | {23'b0, e.ifpc});
  endtask
  task automatic do_reset();
    reset = 1'b1;
    PcSel = 1'b0;
    Stall = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    PcSel = 1'b1;
    BrPC  = 32'h40;
    @(posedge clk);
    #1;
    chk("rst_flush", 32'(Flush_IdEx), 32'd0);
    chk("rst_pc", 32'(Cur_PC), 32'd0);
    chk("rst_ifid_pc", 32'(IfId_PC), 32'd0);
    chk("rst_instr", IfId_Instr, 32'h0000_0013);
    chk("rst_valid", 32'(IfId_Valid), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_redir", 32'(Redirect_Cnt), 32'd0);
    chk("rst_fetch", 32'(Fetch_Cnt), 32'd0);
    reset = 1'b0;
    step(0, 0, 0, 9'h004, 9'h000, 1, 0);
    step(0, 0, 0, 9'h008, 9'h004, 1, 0);
    step(0, 0, 0, 9'h00C, 9'h008, 1, 0);
    step(0, 0, 0, 9'h010, 9'h00C, 1, 0);
    chk("t1_fetch", 32'(Fetch_Cnt), 32'd4);
    chk("sat_fetch", 32'(s_fetch_cnt), 32'd3);
    PcSel = 1'b1;
    BrPC  = 32'h40;
    #1;
    chk("t2_flush", 32'(Flush_IdEx), 32'd1);
    step(0, 1, 32'h40, 9'h040, 9'h00C, 0, 0);
    chk("t2_nop", IfId_Instr, 32'h0000_0013);
    chk("t2_redir", 32'(Redirect_Cnt), 32'd1);
    step(0, 0, 0, 9'h044, 9'h040, 1, 0);
    step(1, 1, 32'h80, 9'h080, 9'h040, 0, 0);
    chk("t3_redir", 32'(Redirect_Cnt), 32'd2);
    step(0, 0, 0, 9'h084, 9'h080, 1, 0);
    chk("t3_fetch", 32'(Fetch_Cnt), 32'd6);
    Stall = 1'b1;
    #1;
    chk("t3_stall_flush", 32'(Flush_IdEx), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 9'h084, 9'h080, 1, 0);
    chk("t3_stall_fetch", 32'(Fetch_Cnt), 32'd6);
    step(0, 1, 32'h1F8, 9'h1F8, 9'h080, 0, 0);
    step(0, 0, 0, 9'h1FC, 9'h1F8, 1, 0);
    step(0, 0, 0, 9'h000, 9'h1FC, 1, 0);
    step(0, 0, 0, 9'h004, 9'h000, 1, 0);
    chk("t4_fetch", 32'(Fetch_Cnt), 32'd9);
    chk("sat_redir", 32'(s_redirect_cnt), 32'd3);
    PcSel = 1'b1;
    BrPC  = 32'h42;
    #1;
    chk("t5_flush_illegal", 32'(Flush_IdEx), 32'd1);
    step(0, 1, 32'h42, 9'h004, 9'h000, 0, 1);
    chk("t5_redir", 32'(Redirect_Cnt), 32'd3);
    PcSel = 1'b1;
    BrPC  = 32'h40;
    #1;
    chk("t5_halt_flush", 32'(Flush_IdEx), 32'd0);
    step(0, 1, 32'h40, 9'h004, 9'h000, 0, 1);
    step(0, 0, 0, 9'h004, 9'h000, 0, 1);
    chk("t5_halt_fetch", 32'(Fetch_Cnt), 32'd9);
    chk("t5_halt_redir", 32'(Redirect_Cnt), 32'd3);
    do_reset();
    chk("t5_rst_pc", 32'(Cur_PC), 32'd0);
    chk("t5_rst_halted", 32'(Halted), 32'd0);
    step(0, 1, 32'h200, 9'h000, 9'h000, 0, 1);
    chk("t5_range_redir", 32'(Redirect_Cnt), 32'd0);
    do_reset();
    step(0, 0, 0, 9'h004, 9'h000, 1, 0);
    step(0, 1, 32'h20, 9'h020, 9'h000, 0, 0);
    step(0, 1, 32'h30, 9'h030, 9'h000, 0, 0);
    step(0, 0, 0, 9'h034, 9'h030, 1, 0);
    chk("b2b_redir", 32'(Redirect_Cnt), 32'd2);
    chk("b2b_fetch", 32'(Fetch_Cnt), 32'd2);
    PcSel = 1'b1;
    BrPC  = 32'h100;
    reset = 1'b1;
    #1;
    chk("t6_flush", 32'(Flush_IdEx), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    PcSel = 1'b0;
    chk("t6_pc", 32'(Cur_PC), 32'd0);
    chk("t6_valid", 32'(IfId_Valid), 32'd0);
    chk("t6_instr", IfId_Instr, 32'h0000_0013);
    chk("t6_redir", 32'(Redirect_Cnt), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 9'(4 * (i + 1)), 9'(4 * i), 1, 0);
    chk("sat_hold", 32'(s_fetch_cnt), 32'd3);
    chk("t6_fetch", 32'(Fetch_Cnt), 32'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
